monitor_rco: RTL and testbench

Downstream monitor for the 16-bit cascaded counter (four 4-bit stages with modes 00 up, 01 down, 10 down-by-3, 11 parallel load). It consumes the counter's mode controls, its 16-bit output and its final ripple-carry (RCO), and turns each wrap into a discrete event. Per-direction wrap counters saturate. A small FIFO holds a snapshot of each event, which a consumer pops with a valid/ack handshake.

---
 rtl/monitor_rco_if.sv | 33 +++
 rtl/monitor_rco.sv | 120 ++++++++++++
 tb/tb_monitor_rco.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/monitor_rco_if.sv
// Event-monitor port bundle: counter observation inputs, consumer handshake
// and status outputs. The monitor uses the slave modport; the producer/consumer side uses master.
interface monitor_rco_if #(
   parameter int ANCHO     = 16,
   parameter int DEPTH     = 4,
   parameter int ANCHO_CNT = 8
);
   localparam int NIVEL_W = $clog2(DEPTH) + 1;

   logic                 ENB;
   logic [1:0]           MODO;
   logic [ANCHO-1:0]     Q;
   logic                 RCO;
   logic                 CLR;
   logic                 EVT_ACK;
   logic                 EVT_VALID;
   logic [ANCHO-1:0]     EVT_Q;
   logic                 EVT_DIR;
   logic [NIVEL_W-1:0]   NIVEL;
   logic [ANCHO_CNT-1:0] CUENTA_ARR;
   logic [ANCHO_CNT-1:0] CUENTA_ABA;
   logic                 DESBORDE;

   modport master (
      output ENB, MODO, Q, RCO, CLR, EVT_ACK,
      input  EVT_VALID, EVT_Q, EVT_DIR, NIVEL, CUENTA_ARR, CUENTA_ABA, DESBORDE
   );

   modport slave (
      input  ENB, MODO, Q, RCO, CLR, EVT_ACK,
      output EVT_VALID, EVT_Q, EVT_DIR, NIVEL, CUENTA_ARR, CUENTA_ABA, DESBORDE
   );
endinterface

// File: rtl/monitor_rco.sv
// Turns rising edges of the cascaded counter's ripple-carry into wrap events:
// saturating per-direction wrap counts plus a snapshot FIFO popped by valid/ack.
module monitor_rco #(
   parameter int ANCHO     = 16,
   parameter int DEPTH     = 4,
   parameter int ANCHO_CNT = 8
) (
   input  logic         CLK,
   input  logic         RESET_L,
   monitor_rco_if.slave mon
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0]     FULL_LVL = LVL_W'(DEPTH);
   localparam logic [ANCHO_CNT-1:0] CNT_MAX  = {ANCHO_CNT{1'b1}};

   logic                 rco_d_r;
   logic [ANCHO:0]       mem_r [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [LVL_W-1:0]     level_r;
   logic                 valid_r;
   logic [ANCHO_CNT-1:0] cuenta_arr_r;
   logic [ANCHO_CNT-1:0] cuenta_aba_r;
   logic                 desborde_r;

   logic                 event_s;
   logic                 dir_s;
   logic                 pop_s;
   logic                 full_s;
   logic                 push_s;
   logic                 drop_s;
   logic [LVL_W-1:0]     level_nxt_s;
   logic [ANCHO_CNT-1:0] cuenta_arr_nxt_s;
   logic [ANCHO_CNT-1:0] cuenta_aba_nxt_s;

   // Event detection, push/pop arbitration and next occupancy/count values
   always_comb begin
      event_s          = mon.RCO & ~rco_d_r & mon.ENB & (mon.MODO != 2'b11);
      dir_s            = (mon.MODO != 2'b00);
      pop_s            = valid_r & mon.EVT_ACK;
      full_s           = (level_r == FULL_LVL);
      // A pop at the same edge frees the slot a full FIFO needs for the push.
      push_s           = event_s & (~full_s | pop_s);
      drop_s           = event_s & full_s & ~pop_s;
      level_nxt_s      = level_r;
      cuenta_arr_nxt_s = cuenta_arr_r;
      cuenta_aba_nxt_s = cuenta_aba_r;

      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_W'(1);
         2'b01:   level_nxt_s = level_r - LVL_W'(1);
         default: level_nxt_s = level_r;
      endcase

      if (event_s && !dir_s && (cuenta_arr_r != CNT_MAX)) begin
         cuenta_arr_nxt_s = cuenta_arr_r + ANCHO_CNT'(1);
      end else begin
         cuenta_arr_nxt_s = cuenta_arr_r;
      end

      if (event_s && dir_s && (cuenta_aba_r != CNT_MAX)) begin
         cuenta_aba_nxt_s = cuenta_aba_r + ANCHO_CNT'(1);
      end else begin
         cuenta_aba_nxt_s = cuenta_aba_r;
      end
   end

   // State update: RCO history, FIFO storage/pointers, counters, sticky overflow
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         rco_d_r      <= 1'b0;
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         level_r      <= '0;
         valid_r      <= 1'b0;
         cuenta_arr_r <= '0;
         cuenta_aba_r <= '0;
         desborde_r   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         // RCO history keeps sampling through CLR so a held carry cannot re-fire.
         rco_d_r <= mon.RCO;
         if (mon.CLR) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            valid_r      <= 1'b0;
            cuenta_arr_r <= '0;
            cuenta_aba_r <= '0;
            desborde_r   <= 1'b0;
         end else begin
            if (push_s) begin
               mem_r[wr_ptr_r] <= {dir_s, mon.Q};
               wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r      <= level_nxt_s;
            valid_r      <= (level_nxt_s != '0);
            cuenta_arr_r <= cuenta_arr_nxt_s;
            cuenta_aba_r <= cuenta_aba_nxt_s;
            if (drop_s) begin
               desborde_r <= 1'b1;
            end
         end
      end
   end

   assign mon.EVT_VALID  = valid_r;
   assign mon.EVT_Q      = mem_r[rd_ptr_r][ANCHO-1:0];
   assign mon.EVT_DIR    = mem_r[rd_ptr_r][ANCHO];
   assign mon.NIVEL      = level_r;
   assign mon.CUENTA_ARR = cuenta_arr_r;
   assign mon.CUENTA_ABA = cuenta_aba_r;
   assign mon.DESBORDE   = desborde_r;
endmodule

// File: tb/tb_monitor_rco.sv
// Directed bench for monitor_rco: counter wrap patterns are driven by hand,
// every expected value is written out as a constant in the sequence below.
module tb_monitor_rco;
   logic clk;
   logic rst_l;
   int   n_chk;
   int   n_fail;

   monitor_rco_if mif ();
   monitor_rco dut (.CLK(clk), .RESET_L(rst_l), .mon(mif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs between edges, then settle just past the edge.
   task automatic d(input logic enb, input logic [1:0] modo, input logic [15:0] q,
                    input logic rco, input logic ack, input logic clr);
      @(negedge clk);
      mif.ENB     = enb;
      mif.MODO    = modo;
      mif.Q       = q;
      mif.RCO     = rco;
      mif.EVT_ACK = ack;
      mif.CLR     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic up_pulse(input logic [15:0] q, input logic ack);
      d(1'b1, 2'b00, q, 1'b1, ack, 1'b0);
      d(1'b1, 2'b00, q, 1'b0, ack, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(mif.EVT_VALID), 32'd0);
      chk({tag, "_nivel"}, 32'(mif.NIVEL), 32'd0);
      chk({tag, "_arr"}, 32'(mif.CUENTA_ARR), 32'd0);
      chk({tag, "_aba"}, 32'(mif.CUENTA_ABA), 32'd0);
      chk({tag, "_desb"}, 32'(mif.DESBORDE), 32'd0);
      chk({tag, "_evtq"}, 32'(mif.EVT_Q), 32'd0);
      chk({tag, "_evtdir"}, 32'(mif.EVT_DIR), 32'd0);
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      rst_l       = 1'b1;
      mif.ENB     = 1'b0;
      mif.MODO    = 2'b00;
      mif.Q       = 16'h0000;
      mif.RCO     = 1'b0;
      mif.CLR     = 1'b0;
      mif.EVT_ACK = 1'b0;
      #1 rst_l = 1'b0;
      #2;
      chk_all_zero("rst");
      @(negedge clk);
      rst_l = 1'b1;

      // Up-count wrap: load, then count through 0xFFFF
      d(1'b1, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0);
      d(1'b1, 2'b00, 16'hFFFD, 1'b0, 1'b0, 1'b0);
      d(1'b1, 2'b00, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      chk("up_pre_valid", 32'(mif.EVT_VALID), 32'd0);
      d(1'b1, 2'b00, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      chk("up_valid", 32'(mif.EVT_VALID), 32'd1);
      chk("up_nivel", 32'(mif.NIVEL), 32'd1);
      chk("up_arr", 32'(mif.CUENTA_ARR), 32'd1);
      chk("up_evtq", 32'(mif.EVT_Q), 32'h0000FFFF);
      chk("up_dir", 32'(mif.EVT_DIR), 32'd0);
      d(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("up_once_nivel", 32'(mif.NIVEL), 32'd1);
      chk("up_once_arr", 32'(mif.CUENTA_ARR), 32'd1);
      d(1'b1, 2'b00, 16'h0001, 1'b0, 1'b1, 1'b0);
      chk("up_pop_valid", 32'(mif.EVT_VALID), 32'd0);
      chk("up_pop_nivel", 32'(mif.NIVEL), 32'd0);

      // Down-count wrap
      d(1'b1, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0);
      d(1'b1, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b0);
      d(1'b1, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b0);
      d(1'b1, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0);
      chk("dn_aba", 32'(mif.CUENTA_ABA), 32'd1);
      chk("dn_arr", 32'(mif.CUENTA_ARR), 32'd1);
      chk("dn_dir", 32'(mif.EVT_DIR), 32'd1);
      chk("dn_evtq", 32'(mif.EVT_Q), 32'h00000000);
      d(1'b1, 2'b01, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      chk("dn_pop_nivel", 32'(mif.NIVEL), 32'd0);

      // Load mode and disabled counter must not produce events
      d(1'b1, 2'b11, 16'h1111, 1'b1, 1'b0, 1'b0);
      chk("load_nivel", 32'(mif.NIVEL), 32'd0);
      chk("load_aba", 32'(mif.CUENTA_ABA), 32'd1);
      d(1'b1, 2'b11, 16'h1111, 1'b0, 1'b0, 1'b0);
      d(1'b0, 2'b00, 16'h2222, 1'b1, 1'b0, 1'b0);
      chk("enb0_nivel", 32'(mif.NIVEL), 32'd0);
      chk("enb0_arr", 32'(mif.CUENTA_ARR), 32'd1);
      d(1'b0, 2'b00, 16'h2222, 1'b0, 1'b0, 1'b0);

      // RCO held five cycles in down-by-3 mode: one event
      d(1'b1, 2'b10, 16'h1234, 1'b1, 1'b0, 1'b0);
      chk("hold_first_nivel", 32'(mif.NIVEL), 32'd1);
      chk("hold_dir", 32'(mif.EVT_DIR), 32'd1);
      chk("hold_evtq", 32'(mif.EVT_Q), 32'h00001234);
      repeat (4) d(1'b1, 2'b10, 16'h1234, 1'b1, 1'b0, 1'b0);
      chk("hold_nivel", 32'(mif.NIVEL), 32'd1);
      chk("hold_aba", 32'(mif.CUENTA_ABA), 32'd2);
      d(1'b1, 2'b10, 16'h1231, 1'b0, 1'b1, 1'b0);
      chk("hold_pop_nivel", 32'(mif.NIVEL), 32'd0);

      // Empty FIFO, event and ack at the same edge: push wins, ack ignored
      d(1'b1, 2'b00, 16'h5555, 1'b1, 1'b1, 1'b0);
      chk("eack_nivel", 32'(mif.NIVEL), 32'd1);
      chk("eack_valid", 32'(mif.EVT_VALID), 32'd1);
      chk("eack_evtq", 32'(mif.EVT_Q), 32'h00005555);
      chk("eack_arr", 32'(mif.CUENTA_ARR), 32'd2);
      d(1'b1, 2'b00, 16'h5556, 1'b0, 1'b1, 1'b0);
      chk("eack_pop_nivel", 32'(mif.NIVEL), 32'd0);

      d(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("clr_arr", 32'(mif.CUENTA_ARR), 32'd0);
      chk("clr_aba", 32'(mif.CUENTA_ABA), 32'd0);

      // Overflow: five events into a four-entry FIFO
      for (int i = 0; i < 5; i++) up_pulse(16'h1000 + 16'(i), 1'b0);
      chk("ovf_nivel", 32'(mif.NIVEL), 32'd4);
      chk("ovf_desb", 32'(mif.DESBORDE), 32'd1);
      chk("ovf_arr", 32'(mif.CUENTA_ARR), 32'd5);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_order_q", 32'(mif.EVT_Q), 32'h1000 + 32'(i));
         d(1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0);
         chk("ovf_step_nivel", 32'(mif.NIVEL), 32'(3 - i));
      end
      chk("ovf_drain_valid", 32'(mif.EVT_VALID), 32'd0);
      chk("ovf_sticky", 32'(mif.DESBORDE), 32'd1);

      // Full FIFO with simultaneous push and pop
      d(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("clr_desb", 32'(mif.DESBORDE), 32'd0);
      chk("clr_nivel", 32'(mif.NIVEL), 32'd0);
      for (int i = 0; i < 4; i++) up_pulse(16'h2000 + 16'(i), 1'b0);
      chk("fpp_fill", 32'(mif.NIVEL), 32'd4);
      d(1'b1, 2'b00, 16'h2004, 1'b1, 1'b1, 1'b0);
      chk("fpp_nivel", 32'(mif.NIVEL), 32'd4);
      chk("fpp_desb", 32'(mif.DESBORDE), 32'd0);
      chk("fpp_arr", 32'(mif.CUENTA_ARR), 32'd5);
      chk("fpp_head", 32'(mif.EVT_Q), 32'h00002001);
      repeat (3) d(1'b1, 2'b00, 16'h2004, 1'b0, 1'b1, 1'b0);
      chk("fpp_tail_q", 32'(mif.EVT_Q), 32'h00002004);
      chk("fpp_tail_nivel", 32'(mif.NIVEL), 32'd1);
      d(1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("fpp_empty", 32'(mif.NIVEL), 32'd0);

      // Saturation after 300 up events
      d(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1);
      repeat (300) up_pulse(16'h0F0F, 1'b1);
      chk("sat_arr", 32'(mif.CUENTA_ARR), 32'd255);
      chk("sat_desb", 32'(mif.DESBORDE), 32'd0);
      chk("sat_nivel", 32'(mif.NIVEL), 32'd0);

      // CLR coincident with an event and a pop
      d(1'b1, 2'b00, 16'h3333, 1'b1, 1'b0, 1'b0);
      chk("sat_hold_arr", 32'(mif.CUENTA_ARR), 32'd255);
      chk("pre_clr_nivel", 32'(mif.NIVEL), 32'd1);
      d(1'b1, 2'b00, 16'h3333, 1'b0, 1'b0, 1'b0);
      d(1'b1, 2'b00, 16'h4444, 1'b1, 1'b1, 1'b1);
      chk("clrev_nivel", 32'(mif.NIVEL), 32'd0);
      chk("clrev_valid", 32'(mif.EVT_VALID), 32'd0);
      chk("clrev_arr", 32'(mif.CUENTA_ARR), 32'd0);
      chk("clrev_aba", 32'(mif.CUENTA_ABA), 32'd0);
      chk("clrev_desb", 32'(mif.DESBORDE), 32'd0);
      d(1'b1, 2'b00, 16'h4444, 1'b1, 1'b0, 1'b0);
      chk("clr_held_nivel", 32'(mif.NIVEL), 32'd0);
      chk("clr_held_arr", 32'(mif.CUENTA_ARR), 32'd0);
      d(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-run with three entries queued
      for (int i = 0; i < 3; i++) up_pulse(16'h6000 + 16'(i), 1'b0);
      chk("mid_nivel", 32'(mif.NIVEL), 32'd3);
      chk("mid_arr", 32'(mif.CUENTA_ARR), 32'd3);
      #2 rst_l = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_l = 1'b1;
      d(1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("post_rst_valid", 32'(mif.EVT_VALID), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
